estado_temp_multicanal: RTL and testbench

- Parametrised multi-channel successor of the single-channel temperature state FSM.
- Supervises NUM_CH scaled temperature channels, each with its own NORMAL/BAJO/ALTO/ALERTA FSM and internal persistence counter.
- Adds return-to-normal hysteresis, an optional latched-alert/acknowledge mode and aggregated alert outputs.
- Sits between the temperature registering stage and actuator/indicator drivers.

---
 rtl/estado_temp_multicanal.sv | 202 ++++++++++++++++++++
 tb/tb_estado_temp_multicanal.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/estado_temp_multicanal.sv
`default_nettype none
// ============================================================================
// Module      : estado_temp_multicanal
// Description : Multi-channel temperature state supervisor. Each channel runs
//               its own NORMAL/BAJO/ALTO/ALERTA FSM with a persistence
//               counter, return-to-normal hysteresis and an optional
//               latched-alert/acknowledge mode. Per-channel alerts are
//               aggregated into a global flag and a lowest-index pointer.
// Ports       : clk           system clock
//               arst          asynchronous reset, active-high
//               valid_i       sample strobe, common to all channels
//               temp_i        packed signed temperatures, ch k at [k*TEMP_W +: TEMP_W]
//               ack_i         global alert acknowledge (latched mode only)
//               alerta        per-channel alert
//               calefactor    per-channel heater enable
//               ventilador    per-channel fan enable
//               estado_o      per-channel state, 2 bits each
//               alerta_global OR of all alerta bits
//               canal_alerta  lowest channel index in alert, 0 if none
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
module estado_temp_multicanal #(
    parameter int NUM_CH      = 4,
    parameter int TEMP_W      = 11,
    parameter int TEMP_BAJO   = 180,
    parameter int TEMP_ALTO   = 259,
    parameter int HIST        = 4,
    parameter int N           = 5,
    parameter int ALERT_LATCH = 0,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     valid_i,
    input  logic [NUM_CH*TEMP_W-1:0] temp_i,
    input  logic                     ack_i,
    output logic [NUM_CH-1:0]        alerta,
    output logic [NUM_CH-1:0]        calefactor,
    output logic [NUM_CH-1:0]        ventilador,
    output logic [2*NUM_CH-1:0]      estado_o,
    output logic                     alerta_global,
    output logic [CH_W-1:0]          canal_alerta
);

    typedef enum logic [1:0] {
        ST_NORMAL = 2'b00,
        ST_BAJO   = 2'b01,
        ST_ALTO   = 2'b10,
        ST_ALERTA = 2'b11
    } state_t;

    localparam logic signed [TEMP_W-1:0] c_bajo   = TEMP_W'(TEMP_BAJO);
    localparam logic signed [TEMP_W-1:0] c_alto   = TEMP_W'(TEMP_ALTO);
    localparam logic signed [TEMP_W-1:0] c_ret_lo = TEMP_W'(TEMP_BAJO + HIST);
    localparam logic signed [TEMP_W-1:0] c_ret_hi = TEMP_W'(TEMP_ALTO - HIST);
    localparam logic [7:0]               c_n      = 8'(N);
    localparam logic                     c_latch  = (ALERT_LATCH != 0);

    // Reject configurations that would make the FSM meaningless.
    if (TEMP_BAJO + HIST > TEMP_ALTO - HIST) begin : g_bad_band
        $error("estado_temp_multicanal: empty return band");
    end
    if (N < 1 || N > 255) begin : g_bad_n
        $error("estado_temp_multicanal: N out of range 1..255");
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        state_t                   r_state, w_state_nxt;
        logic [7:0]               r_cnt, w_cnt_nxt, w_cnt_inc;
        logic                     r_rec, w_rec_nxt;
        logic                     r_cal, w_cal_nxt;
        logic                     r_ven, w_ven_nxt;
        logic signed [TEMP_W-1:0] w_t;
        logic                     w_cold, w_hot, w_ret, w_same_side;

        assign w_t    = temp_i[k*TEMP_W +: TEMP_W];
        assign w_cold = (w_t < c_bajo);
        assign w_hot  = (w_t > c_alto);
        assign w_ret  = (w_t >= c_ret_lo) && (w_t <= c_ret_hi);
        // Anything else (in range but outside the return band) is dead-band.

        assign w_cnt_inc   = (r_cnt >= c_n) ? c_n : (r_cnt + 8'd1);
        assign w_same_side = (w_cold && (r_state == ST_BAJO)) ||
                             (w_hot  && (r_state == ST_ALTO));

        always_ff @(posedge clk or posedge arst) begin
            if (arst) begin
                r_state <= ST_NORMAL;
                r_cnt   <= 8'd0;
                r_rec   <= 1'b0;
                r_cal   <= 1'b0;
                r_ven   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_rec   <= w_rec_nxt;
                r_cal   <= w_cal_nxt;
                r_ven   <= w_ven_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_rec_nxt   = r_rec;
            w_cal_nxt   = r_cal;
            w_ven_nxt   = r_ven;
            case (r_state)
                ST_NORMAL: begin
                    w_cal_nxt = 1'b0;
                    w_ven_nxt = 1'b0;
                    w_rec_nxt = 1'b0;
                    if (valid_i && (w_cold || w_hot)) begin
                        w_cnt_nxt = 8'd1;
                        if (c_n == 8'd1) begin
                            w_state_nxt = ST_ALERTA;
                            w_cal_nxt   = w_cold;
                            w_ven_nxt   = w_hot;
                        end else begin
                            w_state_nxt = w_cold ? ST_BAJO : ST_ALTO;
                        end
                    end
                end
                ST_BAJO, ST_ALTO: begin
                    w_cal_nxt = 1'b0;
                    w_ven_nxt = 1'b0;
                    w_rec_nxt = 1'b0;
                    if (valid_i) begin
                        if (w_same_side) begin
                            w_cnt_nxt = w_cnt_inc;
                            if (w_cnt_inc >= c_n) begin
                                w_state_nxt = ST_ALERTA;
                                w_cal_nxt   = w_cold;
                                w_ven_nxt   = w_hot;
                            end
                        end else if (w_cold || w_hot) begin
                            // Side flip restarts persistence on the new side.
                            w_cnt_nxt   = 8'd1;
                            w_state_nxt = w_cold ? ST_BAJO : ST_ALTO;
                        end else if (w_ret) begin
                            w_state_nxt = ST_NORMAL;
                            w_cnt_nxt   = 8'd0;
                        end
                    end
                end
                ST_ALERTA: begin
                    if (valid_i) begin
                        if (w_cold || w_hot) begin
                            w_cal_nxt = w_cold;
                            w_ven_nxt = w_hot;
                            w_rec_nxt = 1'b0;
                            w_cnt_nxt = ((w_cold && r_ven) || (w_hot && r_cal)) ?
                                        8'd1 : w_cnt_inc;
                        end else if (w_ret) begin
                            w_cal_nxt = 1'b0;
                            w_ven_nxt = 1'b0;
                            if (c_latch) begin
                                w_rec_nxt = 1'b1;
                            end else begin
                                w_state_nxt = ST_NORMAL;
                                w_cnt_nxt   = 8'd0;
                            end
                        end
                    end
                    // Acknowledge is evaluated regardless of valid_i and wins
                    // over any sample on the same edge.
                    if (c_latch && ack_i && (r_rec || (valid_i && w_ret))) begin
                        w_state_nxt = ST_NORMAL;
                        w_cnt_nxt   = 8'd0;
                        w_rec_nxt   = 1'b0;
                        w_cal_nxt   = 1'b0;
                        w_ven_nxt   = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = ST_NORMAL;
                    w_cnt_nxt   = 8'd0;
                    w_rec_nxt   = 1'b0;
                    w_cal_nxt   = 1'b0;
                    w_ven_nxt   = 1'b0;
                end
            endcase
        end

        assign alerta[k]           = (r_state == ST_ALERTA);
        assign calefactor[k]       = r_cal;
        assign ventilador[k]       = r_ven;
        assign estado_o[2*k +: 2]  = r_state;
    end

    assign alerta_global = |alerta;

    // Scan from the top so the lowest alerting index is written last.
    always_comb begin
        canal_alerta = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (alerta[i]) canal_alerta = CH_W'(i);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_estado_temp_multicanal.sv
`default_nettype none
// ============================================================================
// Module      : tb_estado_temp_multicanal
// Description : Self-checking bench for estado_temp_multicanal. Two DUTs are
//               instantiated: auto-clear (ALERT_LATCH=0) and latched
//               (ALERT_LATCH=1). A per-channel behavioural model is compared
//               against both on every falling edge; directed literal checks
//               pin the model at key points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_estado_temp_multicanal;

    localparam int NUM_CH = 4;
    localparam int TEMP_W = 11;
    localparam int N      = 5;

    logic clk = 1'b0;
    logic arst;
    logic valid0, ack0, valid1, ack1;
    logic [NUM_CH*TEMP_W-1:0] temp0, temp1;
    logic [NUM_CH-1:0] al0, cal0, ven0, al1, cal1, ven1;
    logic [2*NUM_CH-1:0] est0, est1;
    logic ag0, ag1;
    logic [1:0] ca0, ca1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    estado_temp_multicanal #(.NUM_CH(NUM_CH), .TEMP_W(TEMP_W), .TEMP_BAJO(180),
        .TEMP_ALTO(259), .HIST(4), .N(N), .ALERT_LATCH(0)) u_dut0 (
        .clk(clk), .arst(arst), .valid_i(valid0), .temp_i(temp0), .ack_i(ack0),
        .alerta(al0), .calefactor(cal0), .ventilador(ven0), .estado_o(est0),
        .alerta_global(ag0), .canal_alerta(ca0));

    estado_temp_multicanal #(.NUM_CH(NUM_CH), .TEMP_W(TEMP_W), .TEMP_BAJO(180),
        .TEMP_ALTO(259), .HIST(4), .N(N), .ALERT_LATCH(1)) u_dut1 (
        .clk(clk), .arst(arst), .valid_i(valid1), .temp_i(temp1), .ack_i(ack1),
        .alerta(al1), .calefactor(cal1), .ventilador(ven1), .estado_o(est1),
        .alerta_global(ag1), .canal_alerta(ca1));

    // ------------------------------------------------------------------
    // Behavioural model: classify the sample, then apply the rules.
    // st uses the output encoding: 0 normal, 1 cold, 2 hot, 3 alert.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [1:0] st;
        int         cnt;
        logic       rec;
        logic       cal;
        logic       ven;
    } mch_t;

    mch_t m0 [NUM_CH];
    mch_t m1 [NUM_CH];

    function automatic int tget(input logic [NUM_CH*TEMP_W-1:0] v, input int k);
        logic signed [TEMP_W-1:0] x;
        x = v[k*TEMP_W +: TEMP_W];
        return int'(x);
    endfunction

    function automatic mch_t mstep(input mch_t s, input int t, input bit v,
                                   input bit ack, input bit latch);
        mch_t n;
        bit cold, hot, ret;
        int side;
        cold = (t < 180);
        hot  = (t > 259);
        ret  = (t >= 184) && (t <= 255);
        n = s;
        if (latch && s.st == 2'd3 && ack && (s.rec || (v && ret))) return '0;
        if (!v) return s;
        if (cold || hot) begin
            side = cold ? 1 : 2;
            if (s.st == 2'd3) begin
                n.cal = cold;
                n.ven = hot;
                n.rec = 1'b0;
            end else begin
                n.cnt = (int'(s.st) == side) ? ((s.cnt + 1 > N) ? N : s.cnt + 1) : 1;
                if (n.cnt >= N) begin
                    n.st  = 2'd3;
                    n.cal = cold;
                    n.ven = hot;
                end else begin
                    n.st = 2'(side);
                end
            end
        end else if (ret) begin
            if (s.st == 2'd3 && latch) begin
                n.cal = 1'b0;
                n.ven = 1'b0;
                n.rec = 1'b1;
            end else begin
                n = '0;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                m0[k] <= '0;
                m1[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                m0[k] <= mstep(m0[k], tget(temp0, k), valid0, ack0, 1'b0);
                m1[k] <= mstep(m1[k], tget(temp1, k), valid1, ack1, 1'b1);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input string tag, input mch_t m [NUM_CH],
                            input logic [2*NUM_CH-1:0] est, input logic [NUM_CH-1:0] al,
                            input logic [NUM_CH-1:0] cal, input logic [NUM_CH-1:0] ven,
                            input logic ag, input logic [1:0] ca);
        logic [2*NUM_CH-1:0] e_est;
        logic [NUM_CH-1:0] e_al, e_cal, e_ven;
        logic [1:0] e_ca;
        e_ca = 2'd0;
        for (int k = 0; k < NUM_CH; k++) begin
            e_est[2*k +: 2] = m[k].st;
            e_al[k]  = (m[k].st == 2'd3);
            e_cal[k] = m[k].cal;
            e_ven[k] = m[k].ven;
        end
        for (int k = NUM_CH - 1; k >= 0; k--) if (e_al[k]) e_ca = 2'(k);
        chk({tag, " estado_o"}, 32'(est), 32'(e_est));
        chk({tag, " alerta"}, 32'(al), 32'(e_al));
        chk({tag, " calefactor"}, 32'(cal), 32'(e_cal));
        chk({tag, " ventilador"}, 32'(ven), 32'(e_ven));
        chk({tag, " alerta_global"}, 32'(ag), 32'(|e_al));
        chk({tag, " canal_alerta"}, 32'(ca), 32'(e_ca));
    endtask

    always @(negedge clk) begin
        cmp_inst("model0", m0, est0, al0, cal0, ven0, ag0, ca0);
        cmp_inst("model1", m1, est1, al1, cal1, ven1, ag1, ca1);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change on the falling edge only.
    // ------------------------------------------------------------------
    task automatic s0(input int a, input int b, input int c, input int d);
        temp0  = {11'(d), 11'(c), 11'(b), 11'(a)};
        valid0 = 1'b1;
        @(negedge clk);
        valid0 = 1'b0;
    endtask

    task automatic gap0();
        temp0  = {11'(300), 11'(300), 11'(100), 11'(300)};
        valid0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic s1(input int a, input bit ack);
        temp1  = {11'(220), 11'(220), 11'(220), 11'(a)};
        valid1 = 1'b1;
        ack1   = ack;
        @(negedge clk);
        valid1 = 1'b0;
        ack1   = 1'b0;
    endtask

    task automatic ack_pulse1();
        ack1 = 1'b1;
        @(negedge clk);
        ack1 = 1'b0;
    endtask

    initial begin
        arst = 1'b1;
        valid0 = 1'b0; ack0 = 1'b0; valid1 = 1'b0; ack1 = 1'b0;
        temp0 = '0; temp1 = '0;
        repeat (3) @(negedge clk);
        chk("reset estado0", 32'(est0), 32'd0);
        chk("reset alerta0", 32'(al0), 32'd0);
        chk("reset act0", 32'({cal0, ven0}), 32'd0);
        chk("reset agg0", 32'({ag0, ca0}), 32'd0);
        chk("reset estado1", 32'(est1), 32'd0);
        arst = 1'b0;
        temp1 = {4{11'(220)}};

        // Cold samples on ch0: BAJO from the first sample, no alert after four.
        s0(100, 220, 220, 220);
        chk("ch0 bajo first", 32'(est0[1:0]), 32'd1);
        repeat (3) s0(100, 220, 220, 220);
        chk("ch0 bajo after 4", 32'(est0[1:0]), 32'd1);
        chk("ch0 no alert after 4", 32'(al0[0]), 32'd0);
        s0(220, 220, 220, 220);
        chk("ch0 back normal", 32'(est0[1:0]), 32'd0);

        // Persistence on ch1 with valid gaps in between.
        repeat (4) begin
            s0(220, 300, 220, 220);
            gap0();
        end
        chk("ch1 alto after 4", 32'(est0[3:2]), 32'd2);
        chk("ch1 no alert after 4", 32'(al0[1]), 32'd0);
        s0(220, 300, 220, 220);
        chk("ch1 alerta after 5", 32'(est0[3:2]), 32'd3);
        chk("ch1 fan after 5", 32'({cal0[1], ven0[1]}), 32'b01);
        gap0();
        s0(220, 258, 220, 220);
        chk("ch1 deadband holds", 32'({est0[3:2], ven0[1]}), 32'b111);
        s0(220, 220, 220, 220);
        chk("ch1 auto clear", 32'({est0, al0, cal0, ven0}), 32'd0);

        // Side flip on ch2.
        s0(220, 220, 100, 220);
        s0(220, 220, 100, 220);
        s0(220, 220, 300, 220);
        chk("ch2 flip to alto", 32'(est0[5:4]), 32'd2);
        repeat (3) s0(220, 220, 300, 220);
        chk("ch2 no alert 6th", 32'({est0[5:4], al0[2]}), 32'b100);
        s0(220, 220, 300, 220);
        chk("ch2 alert 7th", 32'({est0[5:4], ven0[2]}), 32'b111);
        s0(220, 220, 220, 220);

        // Hysteresis on ch3.
        s0(220, 220, 220, 100);
        s0(220, 220, 220, 182);
        chk("ch3 182 stays bajo", 32'(est0[7:6]), 32'd1);
        s0(220, 220, 220, 184);
        chk("ch3 184 normal", 32'(est0[7:6]), 32'd0);
        // Dead-band holds the counter: 1,2,(2),3,4 then alert on 5.
        s0(220, 220, 220, 100);
        s0(220, 220, 220, 100);
        s0(220, 220, 220, 182);
        s0(220, 220, 220, 100);
        s0(220, 220, 220, 100);
        chk("ch3 held count no alert", 32'(est0[7:6]), 32'd1);
        s0(220, 220, 220, 100);
        chk("ch3 held count alert", 32'({est0[7:6], cal0[3], ven0[3]}), 32'b1110);
        s0(220, 220, 220, 184);

        // Aggregation and asynchronous reset mid-alert.
        repeat (5) s0(220, 300, 220, 300);
        chk("agg both", 32'({ag0, ca0}), 32'b101);
        s0(220, 220, 220, 300);
        chk("agg ch3 only", 32'({ag0, ca0}), 32'b111);
        #2 arst = 1'b1;
        #1;
        chk("async rst estado", 32'(est0), 32'd0);
        chk("async rst act", 32'({al0, cal0, ven0}), 32'd0);
        chk("async rst agg", 32'({ag0, ca0}), 32'd0);
        @(negedge clk);
        arst = 1'b0;
        temp0 = {4{11'(220)}};

        // Latched mode on the second instance, ch0 cold side.
        repeat (5) s1(100, 1'b0);
        chk("latch alert heater", 32'({est1[1:0], cal1[0]}), 32'b111);
        s1(100, 1'b1);
        chk("latch ack ignored", 32'({est1[1:0], cal1[0]}), 32'b111);
        s1(220, 1'b0);
        chk("latch recovered", 32'({est1[1:0], al1[0], cal1[0]}), 32'b1110);
        ack_pulse1();
        chk("latch ack exit", 32'({est1[1:0], al1[0]}), 32'd0);
        repeat (5) s1(100, 1'b0);
        s1(220, 1'b1);
        chk("latch ack same edge", 32'({est1[1:0], al1[0], cal1[0]}), 32'd0);
        repeat (5) s1(100, 1'b0);
        s1(220, 1'b0);
        s1(300, 1'b0);
        chk("latch reassert fan", 32'({est1[1:0], cal1[0], ven1[0]}), 32'b1101);
        ack_pulse1();
        chk("latch ack after reassert", 32'(est1[1:0]), 32'd3);
        s1(258, 1'b1);
        chk("latch ack deadband", 32'({est1[1:0], ven1[0]}), 32'b111);
        s1(220, 1'b0);
        ack_pulse1();
        chk("latch final exit", 32'({est1, al1}), 32'd0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
